// File: rtl/priority_encoder_8to3_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | priority_encoder_8to3_pkg : widths, types and helpers for the encoder    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package priority_encoder_8to3_pkg;

   localparam int IN_W  = 8;
   localparam int OUT_W = 3;

   typedef logic [IN_W-1:0]  req_t;
   typedef logic [OUT_W-1:0] idx_t;

   // Clearing the lowest set bit leaves something only if two or more were set.
   function automatic logic is_multi_hot(input req_t v);
      return (v & (v - req_t'(1))) != '0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder_8to3_comb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | priority_encoder_8to3_comb : combinational priority scan of y            |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module priority_encoder_8to3_comb
   import priority_encoder_8to3_pkg::*;
#(
   parameter int unsigned LSB_PRIORITY = 0
) (
   input  logic [IN_W-1:0]  y,
   output logic [OUT_W-1:0] idx,
   output logic             any
);

   // The scan visits bits in rising-priority order so the last hit wins.
   always_comb begin
      idx = '0;
      for (int i = 0; i < IN_W; i++) begin
         if (LSB_PRIORITY != 0) begin
            if (y[IN_W-1-i]) idx = idx_t'(IN_W-1-i);
         end else begin
            if (y[i]) idx = idx_t'(i);
         end
      end
   end

   assign any = |y;

endmodule
`default_nettype wire

// File: rtl/priority_encoder_8to3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | priority_encoder_8to3 : registered 8-to-3 priority encoder, enable/valid |
// | optional multi output via PRIORITY_ENCODER_MULTI_HOT_DET_EN   rev 1.0    |
// +--------------------------------------------------------------------------+
module priority_encoder_8to3
   import priority_encoder_8to3_pkg::*;
#(
   parameter int unsigned LSB_PRIORITY = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  y,
   input  logic             en,
   output logic [OUT_W-1:0] a,
   output logic             valid
`ifdef PRIORITY_ENCODER_MULTI_HOT_DET_EN
   ,
   output logic             multi
`endif
);

   idx_t w_idx;
   logic w_any;
   idx_t a_d, a_q;
   logic valid_d, valid_q;

   priority_encoder_8to3_comb #(
      .LSB_PRIORITY (LSB_PRIORITY)
   ) u_comb (
      .y   (y),
      .idx (w_idx),
      .any (w_any)
   );

   always_comb begin
      a_d     = '0;
      valid_d = 1'b0;
      if (en && w_any) begin
         a_d     = w_idx;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         a_q     <= a_d;
         valid_q <= valid_d;
      end
   end

   assign a     = a_q;
   assign valid = valid_q;

`ifdef PRIORITY_ENCODER_MULTI_HOT_DET_EN
   logic multi_d, multi_q;

   always_comb begin
      multi_d = en && is_multi_hot(y);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) multi_q <= 1'b0;
      else        multi_q <= multi_d;
   end

   assign multi = multi_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_8to3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_priority_encoder_8to3 : directed vectors against both priority modes |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_priority_encoder_8to3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] y;
   logic       en;
   logic [2:0] a_msb, a_lsb;
   logic       valid_msb, valid_lsb;
   logic       multi_msb, multi_lsb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   priority_encoder_8to3 #(.LSB_PRIORITY(0)) dut_msb (
      .clk   (clk),
      .rst_n (rst_n),
      .y     (y),
      .en    (en),
      .a     (a_msb),
      .valid (valid_msb)
`ifdef PRIORITY_ENCODER_MULTI_HOT_DET_EN
      ,
      .multi (multi_msb)
`endif
   );

   priority_encoder_8to3 #(.LSB_PRIORITY(1)) dut_lsb (
      .clk   (clk),
      .rst_n (rst_n),
      .y     (y),
      .en    (en),
      .a     (a_lsb),
      .valid (valid_lsb)
`ifdef PRIORITY_ENCODER_MULTI_HOT_DET_EN
      ,
      .multi (multi_lsb)
`endif
   );

`ifndef PRIORITY_ENCODER_MULTI_HOT_DET_EN
   assign multi_msb = 1'b0;
   assign multi_lsb = 1'b0;
`endif

   typedef struct {
      logic       en;
      logic [7:0] y;
      logic [2:0] a_msb;
      logic [2:0] a_lsb;
      logic       valid;
      logic       multi;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string name, input int e_msb, input int e_lsb,
                            input int e_valid, input int e_multi);
      check({name, " a_msb"}, int'(a_msb), e_msb);
      check({name, " a_lsb"}, int'(a_lsb), e_lsb);
      check({name, " valid_msb"}, int'(valid_msb), e_valid);
      check({name, " valid_lsb"}, int'(valid_lsb), e_valid);
`ifdef PRIORITY_ENCODER_MULTI_HOT_DET_EN
      check({name, " multi_msb"}, int'(multi_msb), e_multi);
      check({name, " multi_lsb"}, int'(multi_lsb), e_multi);
`endif
   endtask

   initial begin
      //        en    y      a_msb a_lsb valid multi
      vecs[0]  = '{1'b1, 8'h05, 3'd2, 3'd0, 1'b1, 1'b1};
      vecs[1]  = '{1'b1, 8'hFF, 3'd7, 3'd0, 1'b1, 1'b1};
      vecs[2]  = '{1'b1, 8'h81, 3'd7, 3'd0, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 8'h40, 3'd0, 3'd0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 8'h01, 3'd0, 3'd0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 8'h10, 3'd4, 3'd4, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 8'h30, 3'd5, 3'd4, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 8'hFF, 3'd0, 3'd0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 8'h60, 3'd6, 3'd5, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 8'h0A, 3'd3, 3'd1, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 8'h80, 3'd7, 3'd7, 1'b1, 1'b0};

      // Reset held with a live request.
      rst_n = 1'b0; en = 1'b1; y = 8'hFF;
      step();
      check_all("reset1", 0, 0, 0, 0);
      step();
      check_all("reset2", 0, 0, 0, 0);
      rst_n = 1'b1;
      step();
      check_all("post_reset", 7, 0, 1, 1);

      // One-hot sweep, each value held three cycles.
      for (int k = 0; k < 8; k++) begin
         y = 8'(1 << k);
         for (int c = 0; c < 3; c++) begin
            step();
            check_all($sformatf("onehot%0d_c%0d", k, c), k, k, 1, 0);
         end
      end

      for (int i = 0; i < 12; i++) begin
         en = vecs[i].en;
         y  = vecs[i].y;
         step();
         check_all($sformatf("vec%0d", i), int'(vecs[i].a_msb), int'(vecs[i].a_lsb),
                   int'(vecs[i].valid), int'(vecs[i].multi));
      end

      // Reset pulse in the middle of a steady request.
      en = 1'b1; y = 8'h20;
      step();
      check_all("mid_pre", 5, 5, 1, 0);
      rst_n = 1'b0;
      step();
      check_all("mid_rst", 0, 0, 0, 0);
      rst_n = 1'b1;
      step();
      check_all("mid_post", 5, 5, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/priority_encoder_8to3.md
Name: priority_encoder_8to3

Overview:
- Registered 8-to-3 priority encoder with enable and a valid flag.
- Takes an 8-bit request vector `y` and outputs the 3-bit index of the highest-priority set bit on `a`.
- Used wherever a request vector must be reduced to a binary index, e.g. interrupt or arbitration front-ends.
- All outputs are registered on one clock with a synchronous, active-low reset.

Parameters:
- LSB_PRIORITY, default 0. When 0, bit 7 has the highest priority. When 1, bit 0 has the highest priority.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active low; sampled on the rising edge of clk.
- y  input  8  request vector.
- en  input  1  encoder enable.
- a  output  3  registered encoded index of the winning request bit.
- valid  output  1  registered flag; high when en=1 and y!=0 were sampled on the previous edge.

Behaviour:
- Reset: on a rising edge with rst_n=0, a<=3'd0 and valid<=0. Reset takes precedence over all other inputs, including mid-operation.
- Latency: exactly 1 clock. The value of y and en sampled at edge N appears on a and valid after edge N.
- The combinational priority function, with LSB_PRIORITY=0:
  - a_next is the index of the highest set bit of y.
  - Examples: y=8'h01 -> 0, 8'h02 -> 1, 8'h04 -> 2, …, 8'h80 -> 7.
  - Multi-hot example: y=8'h05 -> 2 (bit 2 wins).
- With LSB_PRIORITY=1: a_next is the index of the lowest set bit, so y=8'h05 -> 0.
- en=0: a<=0 and valid<=0 regardless of y.
- en=1 and y=8'h00: a<=0 and valid<=0. This is the no-request case; valid distinguishes it from y=8'h01.
- en=1 and y!=0: a<=winning index and valid<=1.
- The registers update every cycle; there is no hold or stall behaviour.
- No X-propagation allowance: every output is fully defined for all input combinations after reset.

Optional Feature:
- Macro: PRIORITY_ENCODER_MULTI_HOT_DET_EN.
- When defined, an extra port is added: multi, output, 1 bit, registered.
  - multi<=1 when en=1 and more than one bit of y is set; otherwise multi<=0.
  - multi resets to 0.
  - Same 1-cycle latency as a and valid.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package priority_encoder_8to3_pkg contains:
  - localparam IN_W=8 and OUT_W=3.
  - typedef logic [IN_W-1:0] req_t.
  - typedef logic [OUT_W-1:0] idx_t.
- One combinational sub-module, priority_encoder_8to3_comb:
  - Inputs: y, plus the LSB_PRIORITY parameter.
  - Outputs: idx and any (OR-reduction of y).
  - Implemented as a for-loop scan.
- The top instantiates the sub-module and holds the output registers and enable gating.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with en=1 and y=8'hFF -> a=0 and valid=0. Release rst_n, and one cycle later a=7 and valid=1.
- One-hot sweep: with en=1, drive y=8'h01, 02, 04, 08, 10, 20, 40, 80, each held 3 cycles -> a=0,1,2,3,4,5,6,7 respectively, one cycle after each change, with valid=1 throughout.
- Multi-hot priority: y=8'h05 -> a=2. y=8'hFF -> a=7. y=8'h81 -> a=7. Repeat with LSB_PRIORITY=1 -> a=0, 0, 0.
- Enable and zero input: en=0 with y=8'h40 -> a=0 and valid=0. en=1 with y=8'h00 -> a=0 and valid=0. en=1 with y=8'h01 -> a=0 and valid=1.
- Reset mid-stream: with y=8'h20 and en=1, pulse rst_n low for one cycle -> a=0 and valid=0 on that edge, then a=5 and valid=1 on the next edge.
- With PRIORITY_ENCODER_MULTI_HOT_DET_EN defined: y=8'h10 -> multi=0. y=8'h30 -> multi=1. en=0 with y=8'hFF -> multi=0.
